// File: rtl/qwi_regmaster.sv
// Register-bus initiator: turns a valid/ready command stream into single-cycle
// register accesses, running partial-mask writes as read-modify-write.
module qwi_regmaster #(
  parameter int REGCNT = 32,
  parameter int AWID   = 12,
  parameter int DWID   = 32
) (
  input  logic              reg_clk,
  input  logic              reg_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [AWID-1:0]   cmd_addr,
  input  logic [DWID-1:0]   cmd_data,
  input  logic [DWID/8-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWID-1:0]   rsp_data,
  output logic              rsp_err,
  output logic              reg_ce,
  output logic [DWID/8-1:0] reg_we,
  output logic [AWID-1:0]   reg_addr,
  output logic [DWID-1:0]   reg_wrd,
  input  logic [DWID-1:0]   reg_rdd,
  output logic              busy
);

  localparam int NB = DWID / 8;
  localparam logic [AWID:0] ADDR_LIM = (AWID + 1)'(REGCNT);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [DWID-1:0]   data_q, data_d;
  logic [NB-1:0]     mask_q, mask_d;
  logic [AWID-1:0]   reg_addr_q, reg_addr_d;
  logic [DWID-1:0]   reg_wrd_q, reg_wrd_d;
  logic [DWID-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_ready_q, rsp_valid_q, reg_ce_q, busy_q;
  logic [NB-1:0]     reg_we_q;
  logic [DWID-1:0]   merged;

  always_comb begin
    merged = reg_rdd;
    for (int unsigned k = 0; k < NB; k++) begin
      if (mask_q[k]) merged[8*k +: 8] = data_q[8*k +: 8];
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    reg_addr_d = reg_addr_q;
    reg_wrd_d  = reg_wrd_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d   = cmd_wr;
          data_d = cmd_data;
          mask_d = cmd_mask;
          if ({1'b0, cmd_addr} >= ADDR_LIM) begin
            state_d    = RSP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            rsp_err_d  = 1'b0;
            reg_addr_d = cmd_addr;
            if (cmd_wr && (&cmd_mask)) begin
              state_d   = WR;
              reg_wrd_d = cmd_data;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (wr_q && (|mask_q)) begin
          state_d   = WR;
          reg_wrd_d = merged;
        end else begin
          state_d    = RSP;
          rsp_data_d = reg_rdd;
        end
      end
      WR: begin
        state_d    = RSP;
        rsp_data_d = reg_wrd_q;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      data_q      <= '0;
      mask_q      <= '0;
      reg_addr_q  <= '0;
      reg_wrd_q   <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      reg_ce_q    <= 1'b0;
      reg_we_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      reg_addr_q  <= reg_addr_d;
      reg_wrd_q   <= reg_wrd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RSP);
      reg_ce_q    <= (state_d == RD) || (state_d == WR);
      reg_we_q    <= (state_d == WR) ? '1 : '0;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign reg_ce    = reg_ce_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wrd   = reg_wrd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_qwi_regmaster.sv
// Directed bench for qwi_regmaster with a 32-entry register-file slave model.
module tb_qwi_regmaster;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_mask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        reg_ce;
  logic [3:0]  reg_we;
  logic [11:0] reg_addr;
  logic [31:0] reg_wrd, reg_rdd;
  logic        busy;

  logic [31:0] regs [32];
  int          ce_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [31:0] last_wrd = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qwi_regmaster #(.REGCNT(32), .AWID(12), .DWID(32)) dut (
    .reg_clk(clk), .reg_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wrd(reg_wrd),
    .reg_rdd(reg_rdd), .busy(busy)
  );

  assign reg_rdd = (reg_addr < 12'd32) ? regs[reg_addr[4:0]] : 32'h0;

  // Slave only commits full-word writes.
  always @(posedge clk) begin
    if (reg_ce) begin
      ce_cnt <= ce_cnt + 1;
      if (reg_we == 4'hF) begin
        wr_cnt   <= wr_cnt + 1;
        last_wrd <= reg_wrd;
        if (reg_addr < 12'd32) regs[reg_addr[4:0]] <= reg_wrd;
      end else if (reg_we == 4'h0) begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, output int lat, output logic [31:0] rdata,
                        output logic err);
    int n;
    cmd_wr = wr; cmd_addr = addr; cmd_data = data; cmd_mask = mask; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; they must be ignored.
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_data = ~data; cmd_mask = ~mask; cmd_wr = ~wr;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    lat = n + 1;
    rdata = rsp_data;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    int          lat, c0, w0, r0, n;
    logic [31:0] d, held;
    logic        e;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_mask = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    #1;
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_reg_ce",    {63'd0, reg_ce},    64'd0);
    chk("rst_reg_we",    {60'd0, reg_we},    64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    do_cmd(1'b1, 12'd5, 32'h1122_3344, 4'hF, lat, d, e);
    do_cmd(1'b1, 12'd7, 32'h0000_00FF, 4'hF, lat, d, e);

    // Full write then read of addr 3
    c0 = ce_cnt; w0 = wr_cnt;
    do_cmd(1'b1, 12'd3, 32'hA5A5_1234, 4'hF, lat, d, e);
    chk("fw_lat",   lat, 2);
    chk("fw_data",  {32'd0, d}, 64'hA5A5_1234);
    chk("fw_err",   {63'd0, e}, 64'd0);
    chk("fw_ce",    ce_cnt - c0, 1);
    chk("fw_we",    wr_cnt - w0, 1);
    chk("fw_reg",   {32'd0, regs[3]}, 64'hA5A5_1234);
    r0 = rd_cnt;
    do_cmd(1'b0, 12'd3, 32'h0, 4'h0, lat, d, e);
    chk("rd_lat",   lat, 2);
    chk("rd_data",  {32'd0, d}, 64'hA5A5_1234);
    chk("rd_bus",   rd_cnt - r0, 1);

    // Partial write (RMW) on addr 5
    c0 = ce_cnt; w0 = wr_cnt; r0 = rd_cnt;
    do_cmd(1'b1, 12'd5, 32'hAABB_CCDD, 4'b0101, lat, d, e);
    chk("pw_lat",   lat, 3);
    chk("pw_data",  {32'd0, d}, 64'h11BB_33DD);
    chk("pw_rd",    rd_cnt - r0, 1);
    chk("pw_wr",    wr_cnt - w0, 1);
    chk("pw_wrd",   {32'd0, last_wrd}, 64'h11BB_33DD);
    chk("pw_reg",   {32'd0, regs[5]}, 64'h11BB_33DD);

    // Out of range
    c0 = ce_cnt;
    do_cmd(1'b0, 12'd32, 32'h0, 4'h0, lat, d, e);
    chk("oor_lat",  lat, 1);
    chk("oor_err",  {63'd0, e}, 64'd1);
    chk("oor_data", {32'd0, d}, 64'd0);
    chk("oor_ce",   ce_cnt - c0, 0);
    do_cmd(1'b1, 12'hFFF, 32'hDEAD_BEEF, 4'hF, lat, d, e);
    chk("oor_wr_err", {63'd0, e}, 64'd1);
    chk("oor_wr_ce",  ce_cnt - c0, 0);

    // mask==0 write is a plain read
    c0 = ce_cnt; w0 = wr_cnt;
    do_cmd(1'b1, 12'd7, 32'h1234_5678, 4'h0, lat, d, e);
    chk("m0_lat",   lat, 2);
    chk("m0_data",  {32'd0, d}, 64'h0000_00FF);
    chk("m0_err",   {63'd0, e}, 64'd0);
    chk("m0_ce",    ce_cnt - c0, 1);
    chk("m0_we",    wr_cnt - w0, 0);
    chk("m0_reg",   {32'd0, regs[7]}, 64'h0000_00FF);

    // Backpressure with cmd_valid held high throughout
    cmd_wr = 1'b0; cmd_addr = 12'd3; cmd_mask = 4'h0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_addr = 12'd5;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_rsp_seen", {63'd0, rsp_valid}, 64'd1);
    held = rsp_data;
    chk("bp_data0", {32'd0, held}, 64'hA5A5_1234);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", {63'd0, rsp_valid}, 64'd1);
      chk("bp_data_hold",  {32'd0, rsp_data}, {32'd0, held});
      chk("bp_cmd_ready",  {63'd0, cmd_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_after_hs_valid", {63'd0, rsp_valid}, 64'd0);
    chk("bp_after_hs_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_next_accept", {63'd0, busy}, 64'd1);
    chk("bp_next_ce",     {63'd0, reg_ce}, 64'd1);
    @(posedge clk); #1;
    chk("bp_next_valid", {63'd0, rsp_valid}, 64'd1);
    chk("bp_next_data",  {32'd0, rsp_data}, 64'h11BB_33DD);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during the RD phase of an RMW
    w0 = wr_cnt;
    cmd_wr = 1'b1; cmd_addr = 12'd7; cmd_data = 32'h1234_5678; cmd_mask = 4'b0001;
    cmd_valid = 1'b1;
    chk("rr_ready", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rr_in_rd_ce",   {63'd0, reg_ce}, 64'd1);
    chk("rr_in_rd_we",   {60'd0, reg_we}, 64'd0);
    chk("rr_in_rd_addr", {52'd0, reg_addr}, 64'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_ce",    {63'd0, reg_ce},    64'd0);
    chk("rr_we",    {60'd0, reg_we},    64'd0);
    chk("rr_busy",  {63'd0, busy},      64'd0);
    chk("rr_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rr_data",  {32'd0, rsp_data},  64'd0);
    chk("rr_addr",  {52'd0, reg_addr},  64'd0);
    chk("rr_wrd",   {32'd0, reg_wrd},   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rr_no_wr",    wr_cnt - w0, 0);
    chk("rr_reg7",     {32'd0, regs[7]}, 64'h0000_00FF);
    chk("rr_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rr_valid_post", {63'd0, rsp_valid}, 64'd0);
    do_cmd(1'b0, 12'd7, 32'h0, 4'h0, lat, d, e);
    chk("rr_readback", {32'd0, d}, 64'h0000_00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
